// File: rtl/matrix_result_drain.sv
// Result drain for the matrix multiplier: buffers C rows written by the engine
// in a small row FIFO and serializes them as a tagged element stream.
module matrix_result_drain #(
  parameter int SIZE_COUNT = 8,
  parameter int SIZE_WIDTH = $clog2(SIZE_COUNT),
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [1:0][SIZE_WIDTH-1:0]             mat_c_size,
  input  logic                                   mat_c_write,
  input  logic [ADDR_WIDTH-1:0]                  mat_c_address,
  input  logic [SIZE_COUNT-1:0][DATA_WIDTH-1:0]  mat_c_write_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [SIZE_WIDTH-1:0]                  out_row,
  output logic [SIZE_WIDTH-1:0]                  out_col,
  output logic                                   out_last,
  output logic                                   overflow,
  output logic                                   busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [SIZE_WIDTH-1:0]                  fifo_row  [FIFO_DEPTH];
  logic [SIZE_COUNT-1:0][DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [SIZE_WIDTH-1:0] row_last, col_last, col_cnt, row_cnt;
  logic                  full, push, drop, fire, pop, run;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^mat_c_address[ADDR_WIDTH-1:SIZE_WIDTH];

  // Stream handshake: an element transfers on a cycle where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, every
  // out_* field holds and out_valid stays high.
  assign run  = (state == RUN);
  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign push = run && mat_c_write && !full;
  assign drop = run && mat_c_write && full;
  assign fire = out_valid && out_ready;
  assign pop  = fire && (col_cnt == col_last);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (fire && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come straight from the FIFO head, so a row written into an empty
  // FIFO is visible the very next cycle and a stall cannot disturb them.
  always_comb begin
    busy      = run;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (run && (count != '0)) begin
      out_valid = 1'b1;
      out_data  = fifo_data[rd_ptr][col_cnt];
      out_row   = fifo_row[rd_ptr];
      out_col   = col_cnt;
      out_last  = (col_cnt == col_last) && (row_cnt == row_last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      row_last <= '0;
      col_last <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        row_last <= mat_c_size[0];
        col_last <= mat_c_size[1];
        overflow <= 1'b0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else if (fire) begin
        col_cnt <= col_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_row[wr_ptr]  <= mat_c_address[SIZE_WIDTH-1:0];
      fifo_data[wr_ptr] <= mat_c_write_data;
    end
  end

endmodule
